// File: rtl/save_bank_pkg.sv
// Shared types for the save bank.
// The SAVE_BANK_UNDO_EN build option adds undo history. When it is set, the
// undo entry struct is declared inside save_bank, because its field widths
// depend on that module's parameters.
package save_bank_pkg;

  // Top-level control state: either accepting saves or sweeping the slots to zero.
  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_CLEAR = 1'b1
  } sb_state_t;

  // Number of address bits for a bank of n slots. Never returns less than 1.
  function automatic int sb_addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/save_bank_if.sv
// Save/read/control bundle between the number datapath and the save bank.
// The master side drives requests. The slave side is the bank itself.
// The undo signals only do something in SAVE_BANK_UNDO_EN builds.
interface save_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             save_valid;
  logic             save_ready;
  logic [AW-1:0]    save_addr;
  logic [WIDTH-1:0] save_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             clear_req;
  logic             busy;
  logic [DEPTH-1:0] valid_mask;
  logic             addr_err;
  logic             undo_req;
  logic             undo_err;

  modport master (
    output save_valid, save_addr, save_data, rd_addr, clear_req, undo_req,
    input  save_ready, rd_data, busy, valid_mask, addr_err, undo_err
  );

  modport slave (
    input  save_valid, save_addr, save_data, rd_addr, clear_req, undo_req,
    output save_ready, rd_data, busy, valid_mask, addr_err, undo_err
  );
endinterface

// File: rtl/save_bank_undo_stack.sv
// Circular LIFO that holds undo history. When the stack is full, a push
// overwrites the oldest entry, so the newest N entries are always the ones
// available. flush empties the stack and takes priority over push and pop.
// This module is instantiated only when SAVE_BANK_UNDO_EN is defined.
module save_bank_undo_stack
  import save_bank_pkg::*;
#(
  parameter int ENTRY_W = 11,
  parameter int N       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] top_data,
  output logic               empty
);
  localparam int PW = sb_addr_bits(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  logic [ENTRY_W-1:0] entries [N];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      top_idx;
  logic [CW-1:0]      count;

  assign top_idx  = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign top_data = entries[top_idx];
  assign empty    = (count == '0);

  // Pointer and occupancy. The count saturates at N because older entries get overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (count != FULL) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr <= top_idx;
      count  <= count - 1'b1;
    end
  end

  // Entry storage. The count gates every read, so this storage needs no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) entries[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/save_bank.sv
// Bank of DEPTH saved numbers, each WIDTH bits wide, with a 1-cycle registered
// read port, a per-slot written mask, and a clear sequencer that zeroes one
// slot per cycle.
// Defining SAVE_BANK_UNDO_EN adds an UNDO_DEPTH-entry undo history.
// Without it, undo_req is ignored and undo_err is held at 0.
module save_bank
  import save_bank_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int UNDO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  save_bank_if.slave bus
);
  localparam int AW = sb_addr_bits(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  sb_state_t        state;
  logic [AW-1:0]    ptr;
  logic             save_ready_q;
  logic             busy_q;
  logic [WIDTH-1:0] slots [DEPTH];
  logic [DEPTH-1:0] mask_q;
  logic [WIDTH-1:0] rd_q;
  logic             addr_err_q;

  logic save_acc;
  logic save_in;
  logic rd_in;
  logic clear_start;

  assign save_acc    = bus.save_valid && save_ready_q;
  assign save_in     = ({1'b0, bus.save_addr} < DEPTH_W);
  assign rd_in       = ({1'b0, bus.rd_addr} < DEPTH_W);
  assign clear_start = (state == SB_IDLE) && bus.clear_req;

  assign bus.save_ready = save_ready_q;
  assign bus.busy       = busy_q;
  assign bus.valid_mask = mask_q;
  assign bus.rd_data    = rd_q;
  assign bus.addr_err   = addr_err_q;

`ifdef SAVE_BANK_UNDO_EN
  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             valid;
  } undo_entry_t;

  localparam int ENTRY_W = $bits(undo_entry_t);

  undo_entry_t push_entry;
  undo_entry_t top_entry;
  logic        hist_empty;
  logic        undo_ok;
  logic        undo_err_q;

  assign push_entry.addr  = bus.save_addr;
  assign push_entry.data  = slots[bus.save_addr];
  assign push_entry.valid = mask_q[bus.save_addr];

  // Undo is accepted only in IDLE, when the history has an entry and no save is accepted this cycle.
  assign undo_ok = bus.undo_req && (state == SB_IDLE) && !save_acc && !hist_empty;

  save_bank_undo_stack #(
    .ENTRY_W (ENTRY_W),
    .N       (UNDO_DEPTH)
  ) u_undo_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear_start),
    .push      (save_acc && save_in),
    .push_data (push_entry),
    .pop       (undo_ok),
    .top_data  (top_entry),
    .empty     (hist_empty)
  );

  // A refused undo raises a single-cycle error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) undo_err_q <= 1'b0;
    else        undo_err_q <= bus.undo_req && !undo_ok;
  end

  assign bus.undo_err = undo_err_q;
`else
  assign bus.undo_err = 1'b0;
`endif

  // Control FSM. A clear walks ptr 0..DEPTH-1 and then returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SB_IDLE;
      ptr          <= '0;
      save_ready_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        SB_IDLE: begin
          if (bus.clear_req) begin
            state        <= SB_CLEAR;
            ptr          <= '0;
            save_ready_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        SB_CLEAR: begin
          if (ptr == LAST) begin
            state        <= SB_IDLE;
            ptr          <= '0;
            save_ready_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state        <= SB_IDLE;
          ptr          <= '0;
          save_ready_q <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  // Slot storage and written mask. In priority order: clear sweep, then save, then undo restore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
      mask_q <= '0;
    end else if (state == SB_CLEAR) begin
      slots[ptr]  <= '0;
      mask_q[ptr] <= 1'b0;
    end else if (save_acc && save_in) begin
      slots[bus.save_addr]  <= bus.save_data;
      mask_q[bus.save_addr] <= 1'b1;
    end
`ifdef SAVE_BANK_UNDO_EN
    else if (undo_ok) begin
      slots[top_entry.addr]  <= top_entry.data;
      mask_q[top_entry.addr] <= top_entry.valid;
    end
`endif
  end

  // Registered read. A same-cycle save to the read address is bypassed to the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (save_acc && save_in && (bus.save_addr == bus.rd_addr)) begin
      rd_q <= bus.save_data;
    end else if (rd_in) begin
      rd_q <= slots[bus.rd_addr];
    end else begin
      rd_q <= '0;
    end
  end

  // An accepted save to an address outside the bank raises a single-cycle error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_q <= 1'b0;
    else        addr_err_q <= save_acc && !save_in;
  end

endmodule

// File: tb/tb_save_bank.sv
// Testbench for save_bank: a 4-slot instance checked against a behavioural
// model and a read-data scoreboard, plus a 5-slot instance for addresses past
// the top of the bank. Undo expectations follow SAVE_BANK_UNDO_EN.
module tb_save_bank;
  localparam int UD = 4;

  logic clk;
  logic rst_n;

  save_bank_if #(.WIDTH(8), .DEPTH(4)) bus  ();
  save_bank_if #(.WIDTH(8), .DEPTH(5)) bus5 ();

  save_bank #(.WIDTH(8), .DEPTH(4), .UNDO_DEPTH(UD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  save_bank #(.WIDTH(8), .DEPTH(5), .UNDO_DEPTH(UD)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         addr;
    logic [7:0] data;
    logic       v;
  } hent_t;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] m_mem [4];
  logic [3:0] m_mask;
  logic       m_busy;
  int         m_ptr;
  hent_t      hist [$];
  logic [7:0] rd_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
    m_mask = 4'b0000;
    m_busy = 1'b0;
    m_ptr  = 0;
    hist.delete();
    rd_q.delete();
  endtask

  // One clock on the 4-slot instance: predict, push the expected read, clock, then check.
  task automatic cyc(input logic sv, input int sa, input logic [7:0] sd,
                     input int ra, input logic cr, input logic ur);
    logic  acc, ok, e_uerr;
    hent_t h;
    bus.save_valid = sv;
    bus.save_addr  = sa[1:0];
    bus.save_data  = sd;
    bus.rd_addr    = ra[1:0];
    bus.clear_req  = cr;
    bus.undo_req   = ur;
    acc = sv && !m_busy;
    rd_q.push_back((acc && sa == ra) ? sd : m_mem[ra]);
`ifdef SAVE_BANK_UNDO_EN
    ok     = ur && !m_busy && !acc && (hist.size() > 0);
    e_uerr = ur && !ok;
`else
    ok     = 1'b0;
    e_uerr = 1'b0;
`endif
    if (m_busy) begin
      m_mem[m_ptr]  = 8'h00;
      m_mask[m_ptr] = 1'b0;
      m_ptr++;
      if (m_ptr == 4) m_busy = 1'b0;
    end else begin
      if (acc) begin
        h.addr = sa; h.data = m_mem[sa]; h.v = m_mask[sa];
        hist.push_back(h);
        if (hist.size() > UD) void'(hist.pop_front());
        m_mem[sa]  = sd;
        m_mask[sa] = 1'b1;
      end else if (ok) begin
        h = hist.pop_back();
        m_mem[h.addr]  = h.data;
        m_mask[h.addr] = h.v;
      end
      if (cr) begin
        m_busy = 1'b1;
        m_ptr  = 0;
        hist.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("rd_data", bus.rd_data, rd_q.pop_front());
    chk("valid_mask", bus.valid_mask, m_mask);
    chk("busy", bus.busy, m_busy);
    chk("save_ready", bus.save_ready, !m_busy);
    chk("addr_err", bus.addr_err, 1'b0);
    chk("undo_err", bus.undo_err, e_uerr);
  endtask

  // One clock on the 5-slot instance.
  task automatic cyc5(input logic sv, input int sa, input logic [7:0] sd, input int ra);
    bus5.save_valid = sv;
    bus5.save_addr  = sa[2:0];
    bus5.save_data  = sd;
    bus5.rd_addr    = ra[2:0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_data"}, bus.rd_data, 8'h00);
    chk({tag, "_mask"}, bus.valid_mask, 4'b0000);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_ready"}, bus.save_ready, 1'b1);
    chk({tag, "_addr_err"}, bus.addr_err, 1'b0);
    chk({tag, "_undo_err"}, bus.undo_err, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.save_valid = 0; bus.save_addr = 0; bus.save_data = 0; bus.rd_addr = 0;
    bus.clear_req = 0; bus.undo_req = 0;
    bus5.save_valid = 0; bus5.save_addr = 0; bus5.save_data = 0; bus5.rd_addr = 0;
    bus5.clear_req = 0; bus5.undo_req = 0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic save, then read it back.
    cyc(1, 2, 8'hA5, 0, 0, 0);
    cyc(0, 0, 8'h00, 2, 0, 0);
    // Save with a same-cycle read of the same slot goes through the bypass.
    cyc(1, 1, 8'h3C, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, i, 0, 0);

    // Fill all slots, clear while a save is held, then read everything back.
    for (int i = 0; i < 4; i++) cyc(1, i, 8'h10 + 8'(i), 3 - i, 0, 0);
    cyc(0, 0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, i % 4, 8'hFF, i % 4, (i == 1), 0);
    cyc(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, i, 0, 0);

    // Save and clear_req in the same cycle: the save lands, then the clear erases it.
    cyc(1, 3, 8'h99, 3, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 3, 0, 0);

    // Undo sequence. In a default build these undo requests are ignored.
    cyc(1, 0, 8'h11, 0, 0, 0);
    cyc(1, 0, 8'h22, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    cyc(0, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < UD + 1; i++) cyc(1, 1, 8'h01 + 8'(i), 1, 0, 0);
    for (int i = 0; i < UD + 1; i++) cyc(0, 0, 8'h00, 1, 0, 1);
    cyc(1, 2, 8'h44, 2, 0, 1);
    cyc(0, 0, 8'h00, 2, 0, 1);
    cyc(0, 0, 8'h00, 1, 0, 0);

    // Reset asserted two cycles into a clear.
    for (int i = 0; i < 4; i++) cyc(1, i, 8'hC0 + 8'(i), i, 0, 0);
    cyc(0, 0, 8'h00, 0, 1, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midclear_rst");
    model_reset();
    bus.save_valid = 0; bus.clear_req = 0; bus.undo_req = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 8'h00, 0, 0, 0);
    cyc(1, 1, 8'h5E, 0, 0, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, i, 0, 0);

    // 5-slot instance: saves to addresses past the top of the bank.
    cyc5(1, 7, 8'h5A, 7);
    chk("d5_addr_err_hi", bus5.addr_err, 1'b1);
    chk("d5_mask_a", bus5.valid_mask, 5'b00000);
    chk("d5_rd_oor", bus5.rd_data, 8'h00);
    cyc5(0, 0, 8'h00, 4);
    chk("d5_addr_err_lo", bus5.addr_err, 1'b0);
    chk("d5_rd4_empty", bus5.rd_data, 8'h00);
    cyc5(1, 4, 8'h77, 4);
    chk("d5_bypass", bus5.rd_data, 8'h77);
    chk("d5_mask_b", bus5.valid_mask, 5'b10000);
    chk("d5_addr_err_in", bus5.addr_err, 1'b0);
    cyc5(1, 5, 8'h12, 4);
    chk("d5_rd4", bus5.rd_data, 8'h77);
    chk("d5_addr_err_5", bus5.addr_err, 1'b1);
    chk("d5_mask_c", bus5.valid_mask, 5'b10000);
    cyc5(0, 0, 8'h00, 6);
    chk("d5_rd6", bus5.rd_data, 8'h00);
    chk("d5_addr_err_end", bus5.addr_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
